// File: rtl/trap_redirect_unit.sv
// -----------------------------------------------------------------------------
// trap_redirect_unit
//
// Purpose:
//   Turns pipeline exception / ECALL / MRET events into a flush, a short
//   pipeline drain, and a redirect of the fetch stage. The event is accepted
//   in IDLE. Flush and commit pulses are issued in that same cycle. The unit
//   then waits DRAIN_CYCLES enabled cycles and holds a redirect request until
//   fetch accepts it.
//
// Parameters:
//   XLEN          width code; datapath width W = 1 << (XLEN + 4)
//                 (0 -> 16, 1 -> 32, 2 -> 64 bits)
//   DRAIN_CYCLES  enabled cycles spent in DRAIN before REDIRECT (1..7)
//
// Ports:
//   i_clk                    clock, rising edge
//   i_rst                    asynchronous active-low reset
//   i_clk_en                 global clock enable
//   i_exception_code_f_d_ff  D-stage exception code, 4'hF = none
//   i_exception_code_e_m_ff  M-stage exception code, 4'hF = none
//   i_ecall_d                D-stage ECALL decoded
//   i_mret_d                 D-stage MRET decoded
//   i_mtvec                  mtvec CSR (direct mode only)
//   i_mepc                   mepc CSR
//   i_redirect_ready         fetch accepts the redirect
//   o_flush_f_d/_d_e/_e_m    pipeline register flush pulses
//   o_stall_f                hold fetch while the unit is busy
//   o_redirect_valid         redirect request to fetch
//   o_redirect_pc            redirect target (0 when not valid)
//   o_trap_taken             one-cycle pulse: trap committed to CSR file
//   o_mret_e                 one-cycle pulse: MRET committed to CSR file
//   o_busy                   FSM not in IDLE
//   o_dbg_state              current FSM state, for observation only
//
// Redirect handshake (valid/ready):
//   o_redirect_valid rises on entry to REDIRECT and stays high. o_redirect_pc
//   stays stable while it is high. The transfer completes on the first rising
//   edge where o_redirect_valid, i_redirect_ready and i_clk_en are all 1.
//   Valid never depends on ready, and valid is not withdrawn before that
//   edge.
// -----------------------------------------------------------------------------

`ifndef XLEN_16b
`define XLEN_16b 0
`endif
`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module trap_redirect_unit #(
    parameter int XLEN         = `XLEN_64b,
    parameter int DRAIN_CYCLES = 2,
    localparam int W           = 1 << (XLEN + 4)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clk_en,
    input  logic [3:0]   i_exception_code_f_d_ff,
    input  logic [3:0]   i_exception_code_e_m_ff,
    input  logic         i_ecall_d,
    input  logic         i_mret_d,
    input  logic [W-1:0] i_mtvec,
    input  logic [W-1:0] i_mepc,
    input  logic         i_redirect_ready,
    output logic         o_flush_f_d,
    output logic         o_flush_d_e,
    output logic         o_flush_e_m,
    output logic         o_stall_f,
    output logic         o_redirect_valid,
    output logic [W-1:0] o_redirect_pc,
    output logic         o_trap_taken,
    output logic         o_mret_e,
    output logic         o_busy,
    output logic [1:0]   o_dbg_state
);

    // The counter is loaded with DRAIN_CYCLES-1 and DRAIN exits when it
    // reads 0, so the unit spends exactly DRAIN_CYCLES enabled cycles in
    // DRAIN.
    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);
    localparam logic [3:0] NO_EXC     = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t         state;
    logic [2:0]     drain_cnt;
    logic [W-1:0]   target;

    // -------------------------------------------------------------------------
    // Event decode and priority (oldest instruction wins):
    //   M-stage exception > D-stage exception > ECALL > MRET
    // ECALL and MRET together resolve to ECALL. MRET is only taken when no
    // trap source is present.
    // -------------------------------------------------------------------------
    logic m_exc;
    logic d_exc;
    logic accept_en;
    logic take_m_trap;
    logic take_d_trap;
    logic take_mret;
    logic accept;

    logic [W-1:0] trap_target;
    logic [W-1:0] mret_target;

    assign m_exc = (i_exception_code_e_m_ff != NO_EXC);
    assign d_exc = (i_exception_code_f_d_ff != NO_EXC);

    // Qualifying with i_rst keeps every pulse at 0 while reset is held, even
    // when event inputs are active during reset.
    assign accept_en = i_rst && i_clk_en && (state == ST_IDLE);

    assign take_m_trap = accept_en && m_exc;
    assign take_d_trap = accept_en && !m_exc && (d_exc || i_ecall_d);
    assign take_mret   = accept_en && !m_exc && !d_exc && !i_ecall_d && i_mret_d;
    assign accept      = take_m_trap || take_d_trap || take_mret;

    // Only direct-mode mtvec is supported: the mode bits are dropped. mepc
    // bit 0 is always clear for a legal return address.
    assign trap_target = {i_mtvec[W-1:2], 2'b00};
    assign mret_target = {i_mepc[W-1:1], 1'b0};

    // Low bits dropped by the alignment above.
    logic unused_csr_low_bits;
    assign unused_csr_low_bits = ^{i_mtvec[1:0], i_mepc[0]};

    // -------------------------------------------------------------------------
    // FSM, drain counter and latched target.
    // State, counter and target update only on enabled cycles. With i_clk_en
    // low, everything holds.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= ST_IDLE;
            drain_cnt <= 3'd0;
            target    <= '0;
        end else if (i_clk_en) begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                        // The target is captured once here. CSR writes that
                        // land during DRAIN/REDIRECT cannot move it.
                        target    <= take_mret ? mret_target : trap_target;
                    end
                end

                ST_DRAIN: begin
                    if (drain_cnt == 3'd0) begin
                        state <= ST_REDIRECT;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end

                ST_REDIRECT: begin
                    // Returning to IDLE here lets the very next enabled cycle
                    // accept a new event.
                    if (i_redirect_ready) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    drain_cnt <= 3'd0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // Pulses are tied to the accept decision, so they fire in the accept cycle
    // and are 0 whenever i_clk_en is low. Level outputs come only from the
    // registered state.
    // -------------------------------------------------------------------------
    assign o_flush_f_d  = accept;
    assign o_flush_d_e  = accept;
    assign o_flush_e_m  = take_m_trap;
    assign o_trap_taken = take_m_trap || take_d_trap;
    assign o_mret_e     = take_mret;

    assign o_busy           = (state != ST_IDLE);
    assign o_stall_f        = (state != ST_IDLE);
    assign o_redirect_valid = (state == ST_REDIRECT);
    assign o_redirect_pc    = (state == ST_REDIRECT) ? target : '0;
    assign o_dbg_state      = state;

endmodule

// File: tb/tb_trap_redirect_unit.sv
// -----------------------------------------------------------------------------
// tb_trap_redirect_unit
//
// Directed bench for trap_redirect_unit (XLEN = 64-bit, DRAIN_CYCLES = 2).
// Inputs change just after a falling edge. Outputs are sampled 1-2 time units
// later, which is well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_trap_redirect_unit;

    localparam int W = 64;

    // ---------------------------------------------------------------- clock/reset
    logic         clk = 1'b0;
    logic         rst;
    logic         clk_en;
    logic [3:0]   code_f_d;
    logic [3:0]   code_e_m;
    logic         ecall;
    logic         mret;
    logic [W-1:0] mtvec;
    logic [W-1:0] mepc;
    logic         ready;

    logic         flush_f_d;
    logic         flush_d_e;
    logic         flush_e_m;
    logic         stall_f;
    logic         redirect_valid;
    logic [W-1:0] redirect_pc;
    logic         trap_taken;
    logic         mret_e;
    logic         busy;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    trap_redirect_unit #(
        .XLEN         (2),
        .DRAIN_CYCLES (2)
    ) dut (
        .i_clk                   (clk),
        .i_rst                   (rst),
        .i_clk_en                (clk_en),
        .i_exception_code_f_d_ff (code_f_d),
        .i_exception_code_e_m_ff (code_e_m),
        .i_ecall_d               (ecall),
        .i_mret_d                (mret),
        .i_mtvec                 (mtvec),
        .i_mepc                  (mepc),
        .i_redirect_ready        (ready),
        .o_flush_f_d             (flush_f_d),
        .o_flush_d_e             (flush_d_e),
        .o_flush_e_m             (flush_e_m),
        .o_stall_f               (stall_f),
        .o_redirect_valid        (redirect_valid),
        .o_redirect_pc           (redirect_pc),
        .o_trap_taken            (trap_taken),
        .o_mret_e                (mret_e),
        .o_busy                  (busy),
        .o_dbg_state             (dbg_state)
    );

    // ---------------------------------------------------------------- scoreboard
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_events();
        code_f_d = 4'hF;
        code_e_m = 4'hF;
        ecall    = 1'b0;
        mret     = 1'b0;
    endtask

    // Complete a redirect that is currently presented and check the return to IDLE.
    task automatic finish_redirect(input string tag);
        ready = 1'b1;
        step();
        ready = 1'b0;
        #1;
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_valid"}, 64'(redirect_valid), 64'd0);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        rst    = 1'b0;
        clk_en = 1'b1;
        ready  = 1'b0;
        mtvec  = '0;
        mepc   = '0;
        clear_events();
        repeat (2) step();

        // Reset: every output is low even with an event on the inputs.
        code_e_m = 4'h5;
        ecall    = 1'b1;
        #1;
        check("rst_flush_e_m", 64'(flush_e_m), 64'd0);
        check("rst_flush_f_d", 64'(flush_f_d), 64'd0);
        check("rst_trap", 64'(trap_taken), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(redirect_valid), 64'd0);
        check("rst_pc", redirect_pc, 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        clear_events();
        rst = 1'b1;
        step();

        // M-stage exception: three flushes and a trap; redirect after 2 drain cycles.
        mtvec    = 64'h8000_0103;
        code_e_m = 4'h5;
        #1;
        check("m_flush_f_d", 64'(flush_f_d), 64'd1);
        check("m_flush_d_e", 64'(flush_d_e), 64'd1);
        check("m_flush_e_m", 64'(flush_e_m), 64'd1);
        check("m_trap", 64'(trap_taken), 64'd1);
        check("m_mret", 64'(mret_e), 64'd0);
        step();
        clear_events();
        mtvec = 64'hdead_beef;            // late CSR change must not move the target
        #1;
        check("m_d1_busy", 64'(busy), 64'd1);
        check("m_d1_stall", 64'(stall_f), 64'd1);
        check("m_d1_valid", 64'(redirect_valid), 64'd0);
        check("m_d1_pc", redirect_pc, 64'd0);
        check("m_d1_trap", 64'(trap_taken), 64'd0);
        step();
        check("m_d2_valid", 64'(redirect_valid), 64'd0);
        step();
        check("m_r_valid", 64'(redirect_valid), 64'd1);
        check("m_r_pc", redirect_pc, 64'h8000_0100);
        finish_redirect("m");

        // MRET: target from mepc, held stable while ready stays low.
        mepc = 64'h1235;
        mret = 1'b1;
        #1;
        check("mret_pulse", 64'(mret_e), 64'd1);
        check("mret_trap", 64'(trap_taken), 64'd0);
        check("mret_flush_f_d", 64'(flush_f_d), 64'd1);
        check("mret_flush_e_m", 64'(flush_e_m), 64'd0);
        step();
        clear_events();
        mepc = 64'hffff;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            check("mret_r_valid", 64'(redirect_valid), 64'd1);
            check("mret_r_pc", redirect_pc, 64'h1234);
            check("mret_r_pulse", 64'(mret_e), 64'd0);
            step();
        end
        finish_redirect("mret");

        // M-stage exception with ECALL in the same cycle: M-stage wins, one trap.
        mtvec    = 64'h2000_0007;
        code_e_m = 4'h7;
        ecall    = 1'b1;
        #1;
        check("mec_flush_e_m", 64'(flush_e_m), 64'd1);
        check("mec_trap", 64'(trap_taken), 64'd1);
        step();
        code_e_m = 4'hF;                  // ECALL still high but must be ignored
        #1;
        check("mec_d1_trap", 64'(trap_taken), 64'd0);
        check("mec_d1_flush", 64'(flush_f_d), 64'd0);
        step();
        step();
        check("mec_r_pc", redirect_pc, 64'h2000_0004);
        ecall = 1'b0;
        finish_redirect("mec");
        check("mec_no_retake", 64'(trap_taken), 64'd0);

        // ECALL with MRET together: treated as ECALL only.
        mtvec = 64'h3000;
        mepc  = 64'h5000;
        ecall = 1'b1;
        mret  = 1'b1;
        #1;
        check("em_trap", 64'(trap_taken), 64'd1);
        check("em_mret", 64'(mret_e), 64'd0);
        check("em_flush_e_m", 64'(flush_e_m), 64'd0);
        step();
        clear_events();
        step();
        step();
        check("em_r_pc", redirect_pc, 64'h3000);
        finish_redirect("em");

        // D-stage exception, then asynchronous reset in the middle of DRAIN.
        mtvec    = 64'h4000;
        code_f_d = 4'h1;
        #1;
        check("d_flush_f_d", 64'(flush_f_d), 64'd1);
        check("d_flush_d_e", 64'(flush_d_e), 64'd1);
        check("d_flush_e_m", 64'(flush_e_m), 64'd0);
        check("d_trap", 64'(trap_taken), 64'd1);
        step();
        clear_events();
        #1;
        check("d_drain_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        check("d_rst_busy", 64'(busy), 64'd0);
        check("d_rst_stall", 64'(stall_f), 64'd0);
        check("d_rst_valid", 64'(redirect_valid), 64'd0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("d_post_valid", 64'(redirect_valid), 64'd0);
            check("d_post_busy", 64'(busy), 64'd0);
        end

        // Clock enable low for 4 cycles during DRAIN: counter frozen, no pulses.
        mtvec    = 64'h6000;
        code_e_m = 4'h2;
        #1;
        check("ce_trap", 64'(trap_taken), 64'd1);
        step();
        clk_en   = 1'b0;
        code_e_m = 4'h4;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("ce_frz_busy", 64'(busy), 64'd1);
            check("ce_frz_valid", 64'(redirect_valid), 64'd0);
            check("ce_frz_trap", 64'(trap_taken), 64'd0);
            check("ce_frz_flush", 64'(flush_f_d), 64'd0);
            step();
        end
        clk_en   = 1'b1;
        code_e_m = 4'hF;
        #1;
        check("ce_d2_valid", 64'(redirect_valid), 64'd0);
        step();
        check("ce_d3_valid", 64'(redirect_valid), 64'd0);
        step();
        check("ce_r_valid", 64'(redirect_valid), 64'd1);
        check("ce_r_pc", redirect_pc, 64'h6000);
        clk_en = 1'b0;
        ready  = 1'b1;
        step();
        check("ce_r_hold_valid", 64'(redirect_valid), 64'd1);
        clk_en = 1'b1;
        finish_redirect("ce");

        // New M-stage exception during REDIRECT is ignored; accepted once back in IDLE.
        mtvec    = 64'h7000;
        code_e_m = 4'h5;
        step();
        clear_events();
        step();
        step();
        code_e_m = 4'h3;
        mtvec    = 64'h9000;
        #1;
        check("rd_ign_flush", 64'(flush_f_d), 64'd0);
        check("rd_ign_flush_e_m", 64'(flush_e_m), 64'd0);
        check("rd_ign_trap", 64'(trap_taken), 64'd0);
        check("rd_valid", 64'(redirect_valid), 64'd1);
        check("rd_pc", redirect_pc, 64'h7000);
        ready = 1'b1;
        #1;
        check("rd_hs_trap", 64'(trap_taken), 64'd0);
        step();
        ready = 1'b0;
        #1;
        check("rd_re_busy", 64'(busy), 64'd0);
        check("rd_re_flush_e_m", 64'(flush_e_m), 64'd1);
        check("rd_re_trap", 64'(trap_taken), 64'd1);
        step();
        clear_events();
        step();
        step();
        check("rd_re_pc", redirect_pc, 64'h9000);
        finish_redirect("rd");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // ---------------------------------------------------------------- watchdog
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/trap_redirect_unit.md
TRAP_REDIRECT_UNIT -- requirements
Module: trap_redirect_unit

Interface
REQ-001 SHALL have parameter: XLEN, `XLEN_64b, width code; datapath width W = 1<<(XLEN+4).
REQ-002 SHALL have parameter: DRAIN_CYCLES, 2, pipeline drain cycles before redirect (legal range 1..7).
REQ-003 SHALL have ports, one per line: name, direction, width, meaning.
- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- i_clk_en  in  1  global clock enable.
- i_exception_code_f_d_ff  in  4  D-stage exception code; 4'hF = none.
- i_exception_code_e_m_ff  in  4  M-stage exception code; 4'hF = none.
- i_ecall_d  in  1  D-stage ECALL decoded.
- i_mret_d  in  1  D-stage MRET decoded.
- i_mtvec  in  W  current mtvec CSR.
- i_mepc  in  W  current mepc CSR.
- i_redirect_ready  in  1  fetch accepts redirect.
- o_flush_f_d, o_flush_d_e, o_flush_e_m  out  1 each  pipeline register flush pulses.
- o_stall_f  out  1  hold fetch.
- o_redirect_valid  out  1  redirect request to fetch.
- o_redirect_pc  out  W  redirect target.
- o_trap_taken  out  1  one-cycle pulse; trap committed to CSR file.
- o_mret_e  out  1  one-cycle pulse; MRET committed to CSR file.
- o_busy  out  1  FSM not in IDLE.

Function
REQ-004 SHALL implement FSM states IDLE, DRAIN, REDIRECT; 3-bit drain counter.
REQ-005 SHALL evaluate events only in IDLE with i_clk_en=1; inputs ignored in DRAIN/REDIRECT.
REQ-006 SHALL prioritise: M-stage exception > D-stage exception > ECALL > MRET (oldest instruction first).
REQ-007 SHALL, on accepting M-stage exception, pulse o_flush_f_d, o_flush_d_e, o_flush_e_m and o_trap_taken for exactly that cycle.
REQ-008 SHALL, on accepting D-stage exception or ECALL, pulse o_flush_f_d, o_flush_d_e, o_trap_taken; o_flush_e_m stays 0.
REQ-009 SHALL, on accepting MRET, pulse o_flush_f_d, o_flush_d_e, o_mret_e; o_trap_taken stays 0.
REQ-010 SHALL latch target on accept: trap -> {i_mtvec[W-1:2],2'b00} (direct mode only); MRET -> {i_mepc[W-1:1],1'b0}; later CSR changes do not alter it.
REQ-011 SHALL go IDLE->DRAIN on accept, load counter with DRAIN_CYCLES-1, decrement per enabled cycle, go DRAIN->REDIRECT when counter is 0.
REQ-012 SHALL assert o_redirect_valid with stable o_redirect_pc throughout REDIRECT; transition REDIRECT->IDLE on cycle with i_redirect_ready=1 and i_clk_en=1.
REQ-013 SHALL assert o_stall_f whenever state != IDLE; o_busy identical.
REQ-014 SHALL hold o_redirect_pc at 0 whenever o_redirect_valid=0.
REQ-015 SHALL, with i_clk_en=0, freeze state, counter and latched target, and force all pulse outputs to 0; level outputs (valid, stall, busy) keep state-derived values.
REQ-016 SHALL allow a new event accept in the cycle immediately after REDIRECT->IDLE (no dead cycle beyond IDLE itself).
REQ-017 SHALL treat simultaneous i_ecall_d and i_mret_d as ECALL only.

Reset
REQ-018 SHALL, on i_rst=0 (asynchronous, any state incl. mid-DRAIN/REDIRECT), enter IDLE, clear counter and target, drive all outputs 0.
REQ-019 SHALL resume event evaluation on first enabled edge after i_rst returns to 1.

Verification
REQ-020 M-stage code 4'h5, mtvec=0x8000_0103 -> same-cycle three flush pulses + trap_taken; after 2 cycles redirect_valid=1, pc=0x8000_0100; ready=1 -> IDLE.
REQ-021 MRET with mepc=0x1235, ready held 0 for 3 cycles -> redirect_pc=0x1234 stable 3 cycles, o_mret_e pulsed once, no trap_taken.
REQ-022 M-stage code 4'h7 and ECALL same cycle -> flush_e_m=1, target from mtvec, single trap_taken; ECALL not re-taken.
REQ-023 D-stage code 4'h1 accepted, i_rst=0 during DRAIN -> all outputs 0 immediately, IDLE; no redirect after release.
REQ-024 i_clk_en=0 for 4 cycles during DRAIN -> counter frozen; redirect appears DRAIN_CYCLES enabled cycles after accept.
REQ-025 New M-stage exception while in REDIRECT -> ignored, no flush pulse; re-presented in IDLE -> accepted.
